mem_dump_reader: RTL and testbench

- Hardware memory read-out engine; the read-side counterpart of firmware preloading into picorvino memories.
- Walks a word-aligned address range over a picorv32-style native memory port (read-only) and emits each word on a valid/ready stream toward a UART/trace sink or testbench monitor.
- Used for signature dumps and post-run memory inspection without a $readmemh/$writememh back-door.

---
 rtl/mem_dump_reader.sv | 143 ++++++++++++++
 tb/tb_mem_dump_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Read-only memory dump engine: walks a word-aligned range on a native memory port and streams each word.
// Optional running checksum output is enabled by defining MEM_DUMP_READER_CHECKSUM_EN.
module mem_dump_reader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef MEM_DUMP_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, OUT, FIN} state_t;

    // Masking keeps every base_addr bit in use while forcing word alignment.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              memValid_q;
    logic              outValid_q;
    logic              outLast_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  remaining_d;
    logic [DATA_W-1:0] outData_q;
    logic              memAccept;
    logic              outAccept;

    assign memAccept   = memValid_q & mem_ready;
    assign outAccept   = outValid_q & out_ready;
    assign addr_d      = addr_q + ADDR_W'(4);
    assign remaining_d = remaining_q - CNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            memValid_q  <= 1'b0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            outData_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr_q      <= base_addr & ALIGN_MASK;
                            remaining_q <= word_count;
                            busy_q      <= 1'b1;
                            memValid_q  <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                REQ: begin
                    if (memAccept) begin
                        outData_q  <= mem_rdata;
                        outLast_q  <= (remaining_q == CNT_W'(1));
                        memValid_q <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= OUT;
                    end
                end
                OUT: begin
                    if (outAccept) begin
                        outValid_q  <= 1'b0;
                        addr_q      <= addr_d;
                        remaining_q <= remaining_d;
                        if (outLast_q) begin
                            outLast_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= FIN;
                        end else begin
                            memValid_q <= 1'b1;
                            state_q    <= REQ;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_valid = memValid_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = 4'b0000;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_last  = outLast_q;

`ifdef MEM_DUMP_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Sum is only touched on start and on accepted words, so it stays final after done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            checksum_q <= '0;
        end else if (state_q == OUT && outAccept) begin
            checksum_q <= checksum_q + outData_q;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed self-checking bench for mem_dump_reader with a behavioural zero/multi-wait memory.
// Checksum checks are compiled in when MEM_DUMP_READER_CHECKSUM_EN is defined.
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy;
    logic        done;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;
    int memWait = 0;
    int waitCnt = 0;
    int doneCount = 0;
    int memValidCycles = 0;
    int doneBase;
    int mvBase;
    logic [31:0] heldAddr = '0;
    logic [31:0] addrLog[$];

    mem_dump_reader #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0104: return 32'h2222_2222;
            32'h0000_0108: return 32'h3333_3333;
            default:       return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] count);
        base_addr  = base;
        word_count = count;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic waitOutWord(input string tag, input logic [31:0] expData, input logic expLast);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_data"}, out_data, expData);
        checkOutput({tag, "_last"}, out_last, expLast);
    endtask

    // Called one negedge after the final handshake: done must pulse for exactly that cycle.
    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_busy_at_done"}, busy, 0);
        checkOutput({tag, "_outvalid_at_done"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_done_pulse_end"}, done, 0);
        checkOutput({tag, "_done_count"}, doneCount - doneBase, 1);
    endtask

    task automatic checkAddrLog(input string tag, input int n, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [31:0] a2);
        logic [31:0] expAddr[3];
        expAddr[0] = a0;
        expAddr[1] = a1;
        expAddr[2] = a2;
        checkOutput({tag, "_nreq"}, addrLog.size(), n);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_addr%0d", tag, i), (i < addrLog.size()) ? addrLog[i] : 'x, expAddr[i]);
        addrLog.delete();
    endtask

    always @(negedge clk) begin
        if (done) doneCount++;
        if (mem_valid) memValidCycles++;
    end

    // Memory model: answers after memWait stall cycles and checks the request is held meanwhile.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (waitCnt == 0) heldAddr = mem_addr;
                else checkOutput("mem_addr_hold", mem_addr, heldAddr);
                if (waitCnt == memWait) begin
                    mem_ready = 1'b1;
                    mem_rdata = memWord(mem_addr);
                    addrLog.push_back(mem_addr);
                    waitCnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    waitCnt++;
                end
            end else begin
                if (waitCnt != 0) checkOutput("mem_valid_hold", mem_valid, 1);
                mem_ready = 1'b0;
                waitCnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_valid", mem_valid, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wstrb", mem_wstrb, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        checkOutput("rst_checksum", checksum, 0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        // Basic three-word dump, zero-wait memory, sink always ready.
        out_ready = 1'b1;
        doneBase = doneCount;
        applyStimulus(32'h100, 16'd3);
        checkOutput("s1_mem_valid_t1", mem_valid, 1);
        checkOutput("s1_busy_t1", busy, 1);
        checkOutput("s1_mem_addr_t1", mem_addr, 32'h100);
        checkOutput("s1_wstrb", mem_wstrb, 0);
        waitOutWord("s1w0", 32'h1111_1111, 0);
        @(negedge clk);
        waitOutWord("s1w1", 32'h2222_2222, 0);
        @(negedge clk);
        waitOutWord("s1w2", 32'h3333_3333, 1);
        @(negedge clk);
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        checkOutput("s1_checksum", checksum, 32'h6666_6666);
`endif
        checkDone("s1");
        checkAddrLog("s1", 3, 32'h100, 32'h104, 32'h108);

        // Sink stalls for five cycles on the second word.
        doneBase = doneCount;
        applyStimulus(32'h100, 16'd3);
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        checkOutput("s2_checksum_clear", checksum, 0);
`endif
        waitOutWord("s2w0", 32'h1111_1111, 0);
        @(negedge clk);
        out_ready = 1'b0;
        waitOutWord("s2w1", 32'h2222_2222, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("s2_stall%0d_data", i), out_data, 32'h2222_2222);
            checkOutput($sformatf("s2_stall%0d_last", i), out_last, 0);
            checkOutput($sformatf("s2_stall%0d_valid", i), out_valid, 1);
            checkOutput($sformatf("s2_stall%0d_memvalid", i), mem_valid, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        waitOutWord("s2w2", 32'h3333_3333, 1);
        @(negedge clk);
        checkDone("s2");
        checkAddrLog("s2", 3, 32'h100, 32'h104, 32'h108);

        // Memory answers after three wait cycles per request.
        memWait = 3;
        doneBase = doneCount;
        applyStimulus(32'h100, 16'd3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("s3_memvalid_waiting", mem_valid, 1);
        checkOutput("s3_outvalid_waiting", out_valid, 0);
        waitOutWord("s3w0", 32'h1111_1111, 0);
        @(negedge clk);
        waitOutWord("s3w1", 32'h2222_2222, 0);
        @(negedge clk);
        waitOutWord("s3w2", 32'h3333_3333, 1);
        @(negedge clk);
        checkDone("s3");
        checkAddrLog("s3", 3, 32'h100, 32'h104, 32'h108);
        memWait = 0;

        // Zero-length dump: done at t+1, no memory traffic.
        doneBase = doneCount;
        mvBase = memValidCycles;
        applyStimulus(32'h200, 16'd0);
        checkOutput("s4_done_t1", done, 1);
        checkOutput("s4_busy", busy, 0);
        checkOutput("s4_memvalid", mem_valid, 0);
        @(negedge clk);
        checkOutput("s4_done_end", done, 0);
        checkOutput("s4_memvalid_cycles", memValidCycles - mvBase, 0);
        checkOutput("s4_done_count", doneCount - doneBase, 1);
        checkAddrLog("s4", 0, 0, 0, 0);

        // A second start while busy must be ignored.
        doneBase = doneCount;
        applyStimulus(32'h100, 16'd2);
        applyStimulus(32'h200, 16'd5);
        waitOutWord("s5w0", 32'h1111_1111, 0);
        @(negedge clk);
        waitOutWord("s5w1", 32'h2222_2222, 1);
        @(negedge clk);
        checkDone("s5");
        @(negedge clk);
        checkOutput("s5_idle_busy", busy, 0);
        checkOutput("s5_idle_memvalid", mem_valid, 0);
        checkAddrLog("s5", 2, 32'h100, 32'h104, 0);

        // Unaligned base is forced to a word boundary.
        doneBase = doneCount;
        applyStimulus(32'h103, 16'd1);
        checkOutput("s6_mem_addr", mem_addr, 32'h100);
        waitOutWord("s6w0", 32'h1111_1111, 1);
        @(negedge clk);
        checkDone("s6");
        checkAddrLog("s6", 1, 32'h100, 0, 0);

        // Address wraps past the top of the address space.
        doneBase = doneCount;
        applyStimulus(32'hFFFF_FFFC, 16'd2);
        waitOutWord("s7w0", 32'h2152_4113, 0);
        @(negedge clk);
        waitOutWord("s7w1", 32'hDEAD_BEEF, 1);
        @(negedge clk);
        checkDone("s7");
        checkAddrLog("s7", 2, 32'hFFFF_FFFC, 32'h0, 0);

        // Reset mid-dump clears everything at once and never produces done.
        out_ready = 1'b0;
        applyStimulus(32'h100, 16'd3);
        waitOutWord("s8w0", 32'h1111_1111, 0);
        doneBase = doneCount;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("s8_rst_busy", busy, 0);
        checkOutput("s8_rst_done", done, 0);
        checkOutput("s8_rst_memvalid", mem_valid, 0);
        checkOutput("s8_rst_mem_addr", mem_addr, 0);
        checkOutput("s8_rst_outvalid", out_valid, 0);
        checkOutput("s8_rst_out_data", out_data, 0);
        checkOutput("s8_rst_out_last", out_last, 0);
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        checkOutput("s8_rst_checksum", checksum, 0);
`endif
        @(negedge clk);
        #3;
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("s8_after_busy", busy, 0);
        checkOutput("s8_after_memvalid", mem_valid, 0);
        checkOutput("s8_after_outvalid", out_valid, 0);
        checkOutput("s8_no_done", doneCount - doneBase, 0);
        addrLog.delete();

        // A fresh start after reset works normally.
        doneBase = doneCount;
        applyStimulus(32'h108, 16'd1);
        waitOutWord("s9w0", 32'h3333_3333, 1);
        @(negedge clk);
        checkDone("s9");
        checkAddrLog("s9", 1, 32'h108, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
